// File: rtl/boot_packet_loader.sv
// rtl/boot_packet_loader.sv - boot packet stream receiver: assembles 64-bit instructions
// into instruction memory and latches the epilogue/sleep/countdown schedule.
module boot_packet_loader #(
  parameter int DATA_W  = 16,
  parameter int PKT_AW  = 11,
  parameter int IMEM_AW = 12,
  parameter int INST_W  = 4 * DATA_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   io_packet_in_data,
  input  logic [PKT_AW-1:0]   io_packet_in_address,
  input  logic                io_packet_in_valid,
  input  logic                io_restart,
  output logic                io_imem_wen,
  output logic [IMEM_AW-1:0]  io_imem_waddr,
  output logic [INST_W-1:0]   io_imem_wdata,
  output logic [DATA_W-1:0]   io_body_length,
  output logic [DATA_W-1:0]   io_epilogue_length,
  output logic [DATA_W-1:0]   io_sleep_length,
  output logic [DATA_W-1:0]   io_countdown,
  output logic                io_boot_done,
  output logic                io_boot_error
);

  typedef enum logic [2:0] {
    S_WAIT_LEN,
    S_BODY,
    S_EPILOGUE,
    S_SLEEP,
    S_COUNTDOWN,
    S_DONE
  } state_t;

  localparam logic [31:0] MAX_LEN = 32'(1) << IMEM_AW;

  state_t                  state, state_d;
  logic [1:0]              word_cnt, word_cnt_d;
  logic [IMEM_AW-1:0]      inst_cnt, inst_cnt_d;
  logic [3*DATA_W-1:0]     asm_q, asm_d;
  logic                    wen_q, wen_d;
  logic [IMEM_AW-1:0]      waddr_q, waddr_d;
  logic [INST_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       body_q, body_d, epi_q, epi_d, sleep_q, sleep_d, cd_q, cd_d;
  logic                    done_q, done_d, err_q, err_d;
  logic                    is_ctrl, is_body, last_inst;

  assign is_ctrl   = (io_packet_in_address == '0);
  assign is_body   = (io_packet_in_address == PKT_AW'(1));
  // Body length is at most 2^IMEM_AW, so body_length-1 always fits inst_cnt.
  assign last_inst = ({{(DATA_W-IMEM_AW){1'b0}}, inst_cnt} == body_q - DATA_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_WAIT_LEN;
      word_cnt <= '0;
      inst_cnt <= '0;
      asm_q    <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      body_q   <= '0;
      epi_q    <= '0;
      sleep_q  <= '0;
      cd_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_d;
      word_cnt <= word_cnt_d;
      inst_cnt <= inst_cnt_d;
      asm_q    <= asm_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      body_q   <= body_d;
      epi_q    <= epi_d;
      sleep_q  <= sleep_d;
      cd_q     <= cd_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state;
    word_cnt_d = word_cnt;
    inst_cnt_d = inst_cnt;
    asm_d      = asm_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    body_d     = body_q;
    epi_d      = epi_q;
    sleep_d    = sleep_q;
    cd_d       = cd_q;
    done_d     = done_q;
    err_d      = err_q;

    if (io_restart) begin
      state_d    = S_WAIT_LEN;
      word_cnt_d = '0;
      inst_cnt_d = '0;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end else if (io_packet_in_valid) begin
      case (state)
        S_WAIT_LEN: begin
          if (is_ctrl) begin
            body_d = io_packet_in_data;
            if (io_packet_in_data == '0)
              state_d = S_EPILOGUE;
            else if (32'(io_packet_in_data) > MAX_LEN)
              err_d = 1'b1;
            else
              state_d = S_BODY;
          end else begin
            err_d = 1'b1;
          end
        end
        S_BODY: begin
          if (is_body) begin
            if (word_cnt == 2'd3) begin
              wen_d      = 1'b1;
              waddr_d    = inst_cnt;
              wdata_d    = {io_packet_in_data, asm_q};
              inst_cnt_d = inst_cnt + 1'b1;
              word_cnt_d = '0;
              if (last_inst)
                state_d = S_EPILOGUE;
            end else begin
              asm_d[word_cnt*DATA_W +: DATA_W] = io_packet_in_data;
              word_cnt_d = word_cnt + 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        S_EPILOGUE: begin
          if (is_ctrl) begin
            epi_d   = io_packet_in_data;
            state_d = S_SLEEP;
          end else begin
            err_d = 1'b1;
          end
        end
        S_SLEEP: begin
          if (is_ctrl) begin
            sleep_d = io_packet_in_data;
            state_d = S_COUNTDOWN;
          end else begin
            err_d = 1'b1;
          end
        end
        S_COUNTDOWN: begin
          if (is_ctrl) begin
            cd_d    = io_packet_in_data;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  assign io_imem_wen        = wen_q;
  assign io_imem_waddr      = waddr_q;
  assign io_imem_wdata      = wdata_q;
  assign io_body_length     = body_q;
  assign io_epilogue_length = epi_q;
  assign io_sleep_length    = sleep_q;
  assign io_countdown       = cd_q;
  assign io_boot_done       = done_q;
  assign io_boot_error      = err_q;

endmodule

// File: doc/boot_packet_loader.md
Name: boot_packet_loader

Overview:
- Processor-side receiver of the boot packet stream a host or testbench emits into a core.
- Consumes, in order:
  - body length (address 0)
  - 4 x body-length instruction words (address 1)
  - epilogue length, sleep length, countdown (each address 0)
- Assembles each group of four 16-bit words into a 64-bit instruction and writes it to instruction memory.
- Latches the three schedule values and signals boot completion to the core's execute controller.

Parameters:
- DATA_W, 16, packet data width
- PKT_AW, 11, packet address width
- IMEM_AW, 12, instruction memory address width; capacity 2^IMEM_AW instructions
- INST_W, 64, instruction width; fixed at 4*DATA_W

Ports:
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- io_packet_in_data  in  DATA_W  packet payload
- io_packet_in_address  in  PKT_AW  packet destination selector (0 = control, 1 = body word)
- io_packet_in_valid  in  1  packet present this cycle; no backpressure, every valid packet is consumed
- io_restart  in  1  synchronous pulse; abandons any boot and returns to waiting for body length
- io_imem_wen  out  1  instruction write strobe, one cycle
- io_imem_waddr  out  IMEM_AW  instruction index
- io_imem_wdata  out  INST_W  assembled instruction
- io_body_length  out  DATA_W  latched body length
- io_epilogue_length  out  DATA_W  latched epilogue length
- io_sleep_length  out  DATA_W  latched sleep length
- io_countdown  out  DATA_W  latched countdown
- io_boot_done  out  1  level; high from completion until restart or reset
- io_boot_error  out  1  sticky protocol error

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to sWaitLen.
  - All outputs go to 0: wen, waddr, wdata, the four length registers, done, error.
  - The word counter and instruction counter clear.
  - A reset mid-body discards the partially assembled instruction.
- States: sWaitLen -> sBody -> sEpilogue -> sSleep -> sCountdown -> sDone.
- sWaitLen:
  - On a valid address-0 packet: latch data into io_body_length.
  - Data == 0: go to sEpilogue.
  - Data > 2^IMEM_AW: set error and stay in sWaitLen.
  - Otherwise: go to sBody.
- sBody:
  - Each valid address-1 packet fills lane word_cnt (0..3). Lane 0 is wdata[15:0]; lane 3 is wdata[63:48].
  - On the 4th word: the next cycle drives wen=1, waddr=inst_cnt, wdata=assembled value. inst_cnt then increments. Write latency is 1 cycle after the last word.
  - After instruction body_length-1 is accepted: go to sEpilogue.
  - inst_cnt wraps only at 2^IMEM_AW; the length check makes wrapping unreachable.
- sEpilogue, sSleep, sCountdown:
  - Each takes one valid address-0 packet, latches the corresponding register, and advances.
  - Leaving sCountdown: io_boot_done rises the next cycle and stays high in sDone.
- Protocol errors set io_boot_error and leave state and counters unchanged; the offending packet is dropped:
  - a packet with any other address in a state;
  - address 0 in sBody, or address 1 in a control state;
  - any valid packet in sDone.
- io_boot_error clears only on reset or io_restart.
- Invalid cycles (valid=0) change nothing; gaps between packets are allowed anywhere.
- io_restart:
  - Takes priority over a simultaneous valid packet, which is dropped.
  - Clears done, error, and the counters, and returns to sWaitLen.
  - Length registers retain their values until overwritten.
- io_imem_wen is never high for more than one consecutive cycle per instruction and never high outside sBody completion.

Test Plan:
- Nominal boot:
  - Stimulus: len 7, then 28 words at address 1 (instruction 0 = 0x0000_0000_0000_0001, instruction 1 = 0x0000_0000_0011_0000 ...), then 4, 4, 4 at address 0.
  - Required: 7 writes to waddr 0..6 with matching wdata; epilogue/sleep/countdown = 4; done high the cycle after the 3rd control packet.
- Gapped stream: same as nominal with valid low for 3 cycles between every packet -> identical writes and outputs; done is delayed only by the gaps.
- Zero-length body: 0, 2, 5, 9 -> no wen ever; sleep length = 5, countdown = 9; done asserted.
- Wrong address: address-0 packet arrives after 2 body words -> error=1, packet ignored; the remaining 2 words still complete instruction 0 at waddr 0.
- Restart and oversize length:
  - Restart mid-body -> done=0, error=0; a new length 1 plus 4 words writes waddr 0.
  - Length 4097 with IMEM_AW=12 -> error=1, state stays sWaitLen.
- Async reset: assert reset_n low between two clock edges during sBody -> all outputs 0 immediately; a subsequent full boot succeeds.
